// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop input sync, mid-bit sampling on i_tick, framing-error detect.
// Optional parity bit and i_parity_odd port when UART_RX_PARITY_EN is defined.
module uart_rx_os #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                 i_Clock,
   input  logic                 i_reset,
   input  logic                 i_tick,
   input  logic                 i_rx,
`ifdef UART_RX_PARITY_EN
   input  logic                 i_parity_odd,
`endif
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_frame_err,
   output logic                 o_parity_err,
   output logic                 o_busy
);

   localparam int unsigned TW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RX_PARITY_EN
      StParity,
`endif
      StStop,
      StBrkWait
   } state_t;

   state_t                r_state, w_state_d;
   logic                  r_rx_meta, r_rx_s;
   logic [TW-1:0]         r_tick_cnt, w_tick_d;
   logic [BW-1:0]         r_bit_cnt, w_bit_d;
   logic [DATA_BITS-1:0]  r_shift, w_shift_d;
   logic [DATA_BITS-1:0]  r_data, w_data_d;
   logic                  r_valid, w_valid_d;
   logic                  r_frame_err, w_ferr_d;
`ifdef UART_RX_PARITY_EN
   logic                  r_par_odd, w_par_odd_d;
   logic                  r_par_bad, w_par_bad_d;
   logic                  r_parity_err, w_perr_d;
`endif

   always_comb begin
      w_state_d = r_state;
      w_tick_d  = r_tick_cnt;
      w_bit_d   = r_bit_cnt;
      w_shift_d = r_shift;
      w_data_d  = r_data;
      w_valid_d = 1'b0;
      w_ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_odd_d = r_par_odd;
      w_par_bad_d = r_par_bad;
      w_perr_d    = 1'b0;
`endif
      unique case (r_state)
         StIdle: begin
            if (!r_rx_s) begin
               w_state_d = StStart;
               w_tick_d  = '0;
`ifdef UART_RX_PARITY_EN
               w_par_odd_d = i_parity_odd;
`endif
            end
         end
         StStart: begin
            if (i_tick) begin
               if (r_tick_cnt == TICK_MID) begin
                  w_tick_d  = '0;
                  w_bit_d   = '0;
                  // A high line at mid start bit was a glitch
                  w_state_d = r_rx_s ? StIdle : StData;
               end else begin
                  w_tick_d = r_tick_cnt + 1'b1;
               end
            end
         end
         StData: begin
            if (i_tick) begin
               if (r_tick_cnt == TICK_LAST) begin
                  w_tick_d  = '0;
                  // Shift in from the top so the first bit ends up in bit 0
                  w_shift_d = {r_rx_s, r_shift[DATA_BITS-1:1]};
                  w_bit_d   = r_bit_cnt + 1'b1;
                  if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     w_state_d = StParity;
`else
                     w_state_d = StStop;
`endif
                  end
               end else begin
                  w_tick_d = r_tick_cnt + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (i_tick) begin
               if (r_tick_cnt == TICK_LAST) begin
                  w_tick_d    = '0;
                  w_par_bad_d = r_rx_s ^ (^r_shift) ^ r_par_odd;
                  w_state_d   = StStop;
               end else begin
                  w_tick_d = r_tick_cnt + 1'b1;
               end
            end
         end
`endif
         StStop: begin
            if (i_tick) begin
               if (r_tick_cnt == TICK_LAST) begin
                  w_tick_d = '0;
                  if (r_rx_s) begin
                     w_data_d  = r_shift;
                     w_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                     w_perr_d  = r_par_bad;
`endif
                     w_state_d = StIdle;
                  end else begin
                     w_ferr_d  = 1'b1;
                     w_state_d = StBrkWait;
                  end
               end else begin
                  w_tick_d = r_tick_cnt + 1'b1;
               end
            end
         end
         StBrkWait: begin
            if (r_rx_s) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_reset) begin
         r_rx_meta   <= 1'b1;
         r_rx_s      <= 1'b1;
         r_state     <= StIdle;
         r_tick_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_odd    <= 1'b0;
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_rx_meta   <= i_rx;
         r_rx_s      <= r_rx_meta;
         r_state     <= w_state_d;
         r_tick_cnt  <= w_tick_d;
         r_bit_cnt   <= w_bit_d;
         r_shift     <= w_shift_d;
         r_data      <= w_data_d;
         r_valid     <= w_valid_d;
         r_frame_err <= w_ferr_d;
`ifdef UART_RX_PARITY_EN
         r_par_odd    <= w_par_odd_d;
         r_par_bad    <= w_par_bad_d;
         r_parity_err <= w_perr_d;
`endif
      end
   end

   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_frame_err = r_frame_err;
   assign o_busy      = (r_state != StIdle);
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = r_parity_err;
`else
   assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: serial frames in, compared against a frame-level model.
// Honours UART_RX_PARITY_EN (adds parity bits and the parity scenarios).
module tb_uart_rx_os;

   localparam int unsigned BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clocks

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       rx = 1'b1;
   logic       par_odd = 1'b0;
   logic [7:0] data;
   logic       valid, ferr, perr, busy;

   uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
      .i_Clock      (clk),
      .i_reset      (rst),
      .i_tick       (tick),
      .i_rx         (rx),
`ifdef UART_RX_PARITY_EN
      .i_parity_odd (par_odd),
`endif
      .o_data       (data),
      .o_valid      (valid),
      .o_frame_err  (ferr),
      .o_parity_err (perr),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      int unsigned div;
      div = 0;
      forever begin
         @(negedge clk);
         tick = (div == 3);
         div  = (div + 1) % 4;
      end
   end

   // Observed events
   logic [7:0] mon_data[$];
   logic       mon_perr[$];
   int         mon_ferr, mon_busy, mon_overlap, mon_perr_alone;

   initial begin
      mon_ferr = 0; mon_busy = 0; mon_overlap = 0; mon_perr_alone = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (valid) begin
               mon_data.push_back(data);
               mon_perr.push_back(perr);
            end
            if (ferr) mon_ferr++;
            if (valid && ferr) mon_overlap++;
            if (perr && !valid) mon_perr_alone++;
            if (busy) mon_busy++;
         end
      end
   end

   // Frame-level reference model
   logic [7:0] exp_data[$];
   logic       exp_perr[$];
   int         exp_ferr;
   logic [7:0] exp_last;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic clear_all();
      mon_data.delete(); mon_perr.delete();
      mon_ferr = 0; mon_busy = 0; mon_overlap = 0; mon_perr_alone = 0;
      exp_data.delete(); exp_perr.delete(); exp_ferr = 0;
   endtask

   task automatic send_bit(input logic b, input int n_bits);
      rx = b;
      repeat (n_bits * BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int stop_low, input logic par_flip);
      send_bit(1'b0, 1);
      for (int i = 0; i < 8; i++) send_bit(d[i], 1);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ par_odd ^ par_flip, 1);
`endif
      if (stop_low > 0) send_bit(1'b0, stop_low);
      send_bit(1'b1, 1);
      if (stop_low == 0) begin
         exp_data.push_back(d);
`ifdef UART_RX_PARITY_EN
         exp_perr.push_back(par_flip);
`else
         exp_perr.push_back(1'b0);
`endif
         exp_last = d;
      end else begin
         exp_ferr++;
      end
   endtask

   task automatic check_step(input string tag);
      rx = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
      check({tag, "_nvalid"}, mon_data.size(), exp_data.size());
      for (int i = 0; i < exp_data.size(); i++) begin
         if (i < mon_data.size()) begin
            check($sformatf("%s_data%0d", tag, i), mon_data[i], exp_data[i]);
            check($sformatf("%s_perr%0d", tag, i), mon_perr[i], exp_perr[i]);
         end
      end
      check({tag, "_nferr"}, mon_ferr, exp_ferr);
      check({tag, "_overlap"}, mon_overlap, 0);
      check({tag, "_perr_alone"}, mon_perr_alone, 0);
      check({tag, "_held_data"}, data, exp_last);
      check({tag, "_busy_low"}, busy, 0);
      clear_all();
   endtask

   initial begin
      logic [7:0] d5a;
      exp_last = 8'h00;
      clear_all();

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data", data, 0);
      check("rst_valid", valid, 0);
      check("rst_ferr", ferr, 0);
      check("rst_perr", perr, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      clear_all();

      // Single frame
      send_frame(8'hA5, 0, 1'b0);
      check_step("single");

      // Start-bit glitch of 3 ticks
      rx = 1'b0;
      repeat (12) @(negedge clk);
      rx = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      check("glitch_busy_seen", (mon_busy > 0), 1);
      check("glitch_busy_short", (mon_busy <= 32), 1);
      check_step("glitch");

      // Framing error then recovery
      send_frame(8'h3C, 2, 1'b0);
      check_step("frame_err");
      send_frame(8'h81, 0, 1'b0);
      check_step("after_ferr");

      // Back-to-back, then randomized back-to-back
      send_frame(8'h00, 0, 1'b0);
      send_frame(8'hFF, 0, 1'b0);
      send_frame(8'h55, 0, 1'b0);
      check_step("b2b");
      for (int i = 0; i < 6; i++) send_frame(8'($urandom), 0, 1'b0);
      check_step("b2b_rand");

      // Reset during data bit 4 of 0x5A
      d5a = 8'h5A;
      send_bit(1'b0, 1);
      for (int i = 0; i < 4; i++) send_bit(d5a[i], 1);
      rx = d5a[4];
      repeat (BIT_CLKS / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_data", data, 0);
      check("midrst_valid", valid, 0);
      check("midrst_ferr", ferr, 0);
      check("midrst_busy", busy, 0);
      exp_last = 8'h00;
      rx = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      check_step("midrst_quiet");
      send_frame(8'h12, 0, 1'b0);
      check_step("after_rst");

`ifdef UART_RX_PARITY_EN
      par_odd = 1'b0;
      send_frame(8'h07, 0, 1'b0);
      send_frame(8'h07, 0, 1'b1);
      check_step("parity_even");
      par_odd = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 5; i++) send_frame(8'($urandom), 0, 1'($urandom));
      check_step("parity_odd_rand");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- UART receive path; the consumer of the baud-rate tick stream.
- Deserialises an asynchronous serial line (8-N-1 by default) by oversampling on `i_tick`.
- Sits beside the transmitter in the UART core. Delivers one parallel word plus a one-cycle valid strobe per frame, and flags framing errors.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9), sent LSB first.
- OVERSAMPLE, 16, `i_tick` pulses per bit period; even, >= 4.

Ports:
- i_Clock  input  1  system clock; all logic on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_tick  input  1  oversample enable from the baud-rate generator; one-cycle pulse, OVERSAMPLE pulses per bit.
- i_rx  input  1  serial line, asynchronous, idle high.
- o_data  output  DATA_BITS  last received word; held until the next frame completes.
- o_valid  output  1  one-cycle pulse when o_data is updated by a good frame.
- o_frame_err  output  1  one-cycle pulse when the stop bit samples low.
- o_parity_err  output  1  one-cycle pulse on parity mismatch (see Optional Feature).
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset:
  - Synchronous: while i_reset=1 at a clock edge, state=IDLE, o_data=0, o_valid=0, o_frame_err=0, o_parity_err=0, o_busy=0, counters=0.
  - Synchroniser flops are reset to 1.
  - Reset mid-frame abandons the frame with no strobe.
- Input sync:
  - i_rx passes through 2 flops (rx_s) before any use.
  - Line-to-FSM latency is 2 clocks.
- Counters:
  - tick_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is $clog2(DATA_BITS+1) bits.
  - Counters advance only on cycles with i_tick=1; non-tick cycles hold all state except strobes.
- FSM states:
  - IDLE:
    - On rx_s=0, go to START with tick_cnt=0.
    - Detection does not need a tick.
  - START:
    - Count ticks. At tick_cnt==OVERSAMPLE/2-1 (mid start bit), sample rx_s.
    - If rx_s=1 (glitch), go to IDLE; no strobe.
    - If rx_s=0, go to DATA with tick_cnt=0, bit_cnt=0.
  - DATA:
    - At tick_cnt==OVERSAMPLE-1, sample rx_s into shift register bit position bit_cnt (LSB first), reset tick_cnt, increment bit_cnt.
    - After DATA_BITS samples, go to PARITY if the feature is enabled, else to STOP.
  - PARITY (feature only): one bit period, sampled at tick_cnt==OVERSAMPLE-1; go to STOP.
  - STOP: one bit period, sampled at tick_cnt==OVERSAMPLE-1.
    - rx_s=1:
      - Load o_data from the shift register.
      - Pulse o_valid for exactly one clock, on the clock after the sampling edge.
      - Go to IDLE.
    - rx_s=0:
      - Pulse o_frame_err for one clock; o_data is not updated; o_valid stays low.
      - Go to BRK_WAIT.
  - BRK_WAIT: stay until rx_s=1, then go to IDLE. This prevents a break or low line from being taken as a new start bit.
- Mid-bit sampling: all samples are taken at bit centre, ±1 tick.
- Back-to-back frames:
  - A start bit arriving immediately after a stop-bit sample is accepted, because IDLE is re-entered at mid stop bit.
  - No gap is required between frames.
- Strobes: o_valid and o_frame_err are never high in the same cycle. o_parity_err may coincide with o_valid.
- No overrun detection: o_data is simply overwritten by the next good frame.
- o_busy is combinational from state (state != IDLE).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds the PARITY state and an input port i_parity_odd (1 bit; 0=even, 1=odd), sampled at frame start.
  - Received parity is compared against the XOR of the data bits (inverted for odd).
  - On mismatch, o_parity_err pulses in the same cycle that o_valid would.
  - The word is still delivered and o_valid still pulses.
- Undefined:
  - No PARITY state and no i_parity_odd port.
  - o_parity_err is tied to 0.
  - Frame is start + DATA_BITS + stop.

Test Plan:
- Single frame: defaults, i_tick every 4 clocks; send 0xA5 as 8-N-1 (64 clocks per bit) -> exactly one o_valid pulse, o_data=0xA5, o_frame_err=0, o_busy low afterwards.
- Glitch: i_rx low for 3 ticks, then high -> FSM returns to IDLE, no o_valid, no o_frame_err, o_busy pulses high for fewer than 8 ticks.
- Framing error: send 0x3C with the stop bit held low for 2 bit times, then high -> one o_frame_err pulse, no o_valid, o_data keeps its previous value. Then send 0x81 -> o_valid with o_data=0x81.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap -> three o_valid pulses in order, with matching o_data.
- Reset mid-frame: assert i_reset for 1 clock during data bit 4 of 0x5A -> all outputs 0 next clock, no strobe. A subsequent 0x12 frame is received correctly.
- Parity (UART_RX_PARITY_EN, i_parity_odd=0): send 0x07 with parity bit 1 -> o_valid, o_parity_err=0. Send 0x07 with parity bit 0 -> o_valid and o_parity_err both pulse, o_data=0x07.
